// File: rtl/pb_debounce_multi.sv
`timescale 1ns/1ps
// pb_debounce_multi
//   Multi-channel pushbutton debouncer for the game input path.
//   A single shared divider produces a sample tick. Each channel has its own
//   two-flop synchroniser, an N-sample stability filter, press/release edge
//   pulses and a held-key auto-repeat pulse generator.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   btn_in       raw asynchronous button pins (polarity set by ACTIVE_LOW)
//   btn_level    debounced state, 1 = pressed
//   btn_press    one-clk pulse on debounced press
//   btn_release  one-clk pulse on debounced release
//   btn_repeat   one-clk pulse on press and on each auto-repeat
//   tick         one-clk sample strobe, every TICK_DIV clks
module pb_debounce_multi #(
    parameter int unsigned N            = 4,
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned STABLE       = 8,
    parameter int unsigned REPEAT_DELAY = 500,
    parameter int unsigned REPEAT_RATE  = 100,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_press,
    output logic [N-1:0] btn_release,
    output logic [N-1:0] btn_repeat,
    output logic         tick
);

    localparam int unsigned DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RPT_W   = (RPT_MAX > 0) ? $clog2(RPT_MAX + 1) : 1;
    localparam logic [RPT_W:0] DELAY_END = (RPT_W+1)'(REPEAT_DELAY);
    localparam logic [RPT_W:0] RATE_END  = (RPT_W+1)'(REPEAT_RATE);
    localparam logic [RPT_W:0] RPT_ONE   = (RPT_W+1)'(1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

    // ------------------------------------------------------------------
    // Shared sample-tick divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
            tick    <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Input synchroniser, normalised so 1 = pressed
    // ------------------------------------------------------------------
    logic [N-1:0] sync1;
    logic [N-1:0] sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_in ^ {N{ACTIVE_LOW}};
            sync2 <= sync1;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel filter, edge pulses and auto-repeat
    // ------------------------------------------------------------------
    for (genvar ch = 0; ch < N; ch++) begin : g_ch
        logic [STABLE-1:0] shreg;
        logic [STABLE-1:0] shreg_nxt;
        logic              level_q;
        logic              level_nxt;
        logic              press_q;
        logic              press_nxt;
        logic              release_q;
        logic              release_nxt;
        logic              repeat_q;
        logic              repeat_nxt;
        rpt_state_t        state;
        rpt_state_t        state_nxt;
        logic [RPT_W-1:0]  rcnt;
        logic [RPT_W-1:0]  rcnt_nxt;
        logic [RPT_W:0]    rcnt_inc;

        // The level decision looks at the shift register as it will be
        // after this tick's shift, so the outputs move in the clk right
        // after the tick that delivers the STABLE-th agreeing sample.
        always_comb begin
            shreg_nxt   = shreg;
            level_nxt   = level_q;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;
            repeat_nxt  = 1'b0;
            state_nxt   = state;
            rcnt_nxt    = rcnt;
            rcnt_inc    = {1'b0, rcnt} + RPT_ONE;

            if (tick) begin
                shreg_nxt = {shreg[STABLE-2:0], sync2[ch]};
                if ((&shreg_nxt) && !level_q) begin
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else if (!(|shreg_nxt) && level_q) begin
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
                end

                if (release_nxt) begin
                    state_nxt = RPT_IDLE;
                    rcnt_nxt  = '0;
                end else begin
                    case (state)
                        RPT_IDLE: begin
                            if (press_nxt) begin
                                repeat_nxt = 1'b1;
                                rcnt_nxt   = '0;
                                if (REPEAT_DELAY != 0) begin
                                    state_nxt = RPT_DELAY;
                                end
                            end
                        end
                        RPT_DELAY: begin
                            if (level_q) begin
                                if (rcnt_inc == DELAY_END) begin
                                    repeat_nxt = 1'b1;
                                    rcnt_nxt   = '0;
                                    state_nxt  = RPT_REPEAT;
                                end else begin
                                    rcnt_nxt = rcnt_inc[RPT_W-1:0];
                                end
                            end
                        end
                        RPT_REPEAT: begin
                            if (rcnt_inc == RATE_END) begin
                                repeat_nxt = 1'b1;
                                rcnt_nxt   = '0;
                            end else begin
                                rcnt_nxt = rcnt_inc[RPT_W-1:0];
                            end
                        end
                        default: begin
                            state_nxt = RPT_IDLE;
                            rcnt_nxt  = '0;
                        end
                    endcase
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shreg     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
                state     <= RPT_IDLE;
                rcnt      <= '0;
            end else begin
                shreg     <= shreg_nxt;
                level_q   <= level_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
                repeat_q  <= repeat_nxt;
                state     <= state_nxt;
                rcnt      <= rcnt_nxt;
            end
        end

        assign btn_level[ch]   = level_q;
        assign btn_press[ch]   = press_q;
        assign btn_release[ch] = release_q;
        assign btn_repeat[ch]  = repeat_q;
    end

endmodule

// File: tb/tb_pb_debounce_multi.sv
`timescale 1ns/1ps
// tb_pb_debounce_multi
//   Scoreboard bench for pb_debounce_multi. Two instances share clk, rst_n
//   and btn_in: one with auto-repeat enabled, one with REPEAT_DELAY = 0.
//   A behavioural model (sample runs, ticks-held arithmetic) pushes the
//   expected outputs after every clock edge; a monitor pops and compares on
//   the falling edge.
module tb_pb_debounce_multi;

    localparam int N            = 4;
    localparam int TICK_DIV     = 4;
    localparam int STABLE       = 4;
    localparam int REPEAT_DELAY = 3;
    localparam int REPEAT_RATE  = 2;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic [N-1:0] btn_in = '1;

    logic [N-1:0] level_a, press_a, release_a, repeat_a;
    logic [N-1:0] level_b, press_b, release_b, repeat_b;
    logic         tick_a, tick_b;

    pb_debounce_multi #(
        .N(N), .TICK_DIV(TICK_DIV), .STABLE(STABLE),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .ACTIVE_LOW(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
        .btn_level(level_a), .btn_press(press_a), .btn_release(release_a),
        .btn_repeat(repeat_a), .tick(tick_a)
    );

    pb_debounce_multi #(
        .N(N), .TICK_DIV(TICK_DIV), .STABLE(STABLE),
        .REPEAT_DELAY(0), .REPEAT_RATE(REPEAT_RATE), .ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
        .btn_level(level_b), .btn_press(press_b), .btn_release(release_b),
        .btn_repeat(repeat_b), .tick(tick_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         tick;
        logic [N-1:0] level;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] rep_a;
        logic [N-1:0] rep_b;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // ---------------- behavioural model ----------------
    int           m_cyc;
    bit           m_tick;
    logic [N-1:0] m_d1, m_d2;
    bit           m_run_val [N];
    int           m_run_len [N];
    bit           m_level   [N];
    int           m_held    [2][N];

    task automatic model_step();
        exp_t         e;
        logic [N-1:0] smp;
        bit           use_tick;
        bit           pr, rl, rep;
        int           d;
        e = '0;
        if (!rst_n) begin
            m_cyc  = 0;
            m_tick = 1'b0;
            m_d1   = '0;
            m_d2   = '0;
            for (int ch = 0; ch < N; ch++) begin
                m_run_val[ch] = 1'b0;
                m_run_len[ch] = STABLE;
                m_level[ch]   = 1'b0;
                m_held[0][ch] = 0;
                m_held[1][ch] = 0;
            end
            exp_q.delete();
            exp_q.push_back(e);
            return;
        end
        smp      = m_d2;
        use_tick = m_tick;
        m_d2     = m_d1;
        m_d1     = ~btn_in;
        m_cyc    = m_cyc + 1;
        m_tick   = (m_cyc % TICK_DIV) == 0;
        e.tick   = m_tick;
        if (use_tick) begin
            for (int ch = 0; ch < N; ch++) begin
                pr = 1'b0;
                rl = 1'b0;
                if (smp[ch] == m_run_val[ch]) begin
                    if (m_run_len[ch] < STABLE) m_run_len[ch] = m_run_len[ch] + 1;
                end else begin
                    m_run_val[ch] = smp[ch];
                    m_run_len[ch] = 1;
                end
                if (m_run_len[ch] >= STABLE && m_run_val[ch] != m_level[ch]) begin
                    m_level[ch] = m_run_val[ch];
                    if (m_level[ch]) pr = 1'b1;
                    else             rl = 1'b1;
                end
                e.press[ch] = pr;
                e.rel[ch]   = rl;
                for (int i = 0; i < 2; i++) begin
                    d   = (i == 0) ? REPEAT_DELAY : 0;
                    rep = 1'b0;
                    if (pr) begin
                        rep = 1'b1;
                        m_held[i][ch] = 0;
                    end else if (rl) begin
                        m_held[i][ch] = 0;
                    end else if (m_level[ch]) begin
                        m_held[i][ch] = m_held[i][ch] + 1;
                        if (d > 0 && (m_held[i][ch] == d ||
                            (m_held[i][ch] > d && ((m_held[i][ch] - d) % REPEAT_RATE) == 0)))
                            rep = 1'b1;
                    end
                    if (i == 0) e.rep_a[ch] = rep;
                    else        e.rep_b[ch] = rep;
                end
            end
        end
        for (int ch = 0; ch < N; ch++) e.level[ch] = m_level[ch];
        exp_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] expv);
        n_cmp = n_cmp + 1;
        if (act !== expv) begin
            n_err = n_err + 1;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, expv);
        end
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_cmp = n_cmp + 1;
            n_err = n_err + 1;
            $display("FAIL scoreboard_empty @%0t: got 0 entries expected 1", $time);
        end else begin
            e = exp_q.pop_front();
            chk("tick_a",    N'(tick_a), N'(e.tick));
            chk("level_a",   level_a,    e.level);
            chk("press_a",   press_a,    e.press);
            chk("release_a", release_a,  e.rel);
            chk("repeat_a",  repeat_a,   e.rep_a);
            chk("tick_b",    N'(tick_b), N'(e.tick));
            chk("level_b",   level_b,    e.level);
            chk("press_b",   press_b,    e.press);
            chk("release_b", release_b,  e.rel);
            chk("repeat_b",  repeat_b,   e.rep_b);
        end
    end

    // ---------------- stimulus ----------------
    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    int rem [N];

    initial begin
        int nb;
        btn_in = '1;
        rst_n  = 1'b0;
        adv(5);
        rst_n = 1'b1;

        // idle, all released
        adv(100);

        // ch0 press with a short random bounce, then held through repeats
        nb = $urandom_range(2, 5);
        for (int i = 0; i < nb; i++) begin
            btn_in[0] = ~btn_in[0];
            adv(1);
        end
        btn_in[0] = 1'b0;
        adv(40);

        // ch1 chatter every 3 clk while ch0 stays held
        for (int i = 0; i < 20; i++) begin
            btn_in[1] = ~btn_in[1];
            adv(3);
        end
        btn_in[1] = 1'b1;
        adv(30);

        // release ch0
        btn_in[0] = 1'b1;
        adv(60);

        // simultaneous press on ch2/ch3, reset while held, re-press
        btn_in[3:2] = 2'b00;
        adv(30);
        rst_n = 1'b0;
        adv(3);
        rst_n = 1'b1;
        adv(40);
        btn_in[3:2] = 2'b11;
        adv(40);

        // randomized bounce / hold on all channels, one reset in the middle
        for (int ch = 0; ch < N; ch++) rem[ch] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < N; ch++) begin
                if (rem[ch] == 0) begin
                    btn_in[ch] = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 3) == 0) rem[ch] = $urandom_range(1, 3);
                    else                           rem[ch] = $urandom_range(8, 80);
                end
                rem[ch] = rem[ch] - 1;
            end
            if (c == 1500) rst_n = 1'b0;
            if (c == 1502) rst_n = 1'b1;
            adv(1);
        end

        btn_in = '1;
        adv(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
